// File: rtl/env_adsr.sv
// env_adsr - ADSR amplitude envelope for the waveform generator output.
//
// Takes the generator's signed sample and its 48kHz pulse. Each pulse moves a
// gate-driven envelope FSM one step and captures the sample. The following
// cycle scales the captured sample by the updated level and strobes o_valid.
//
// Ports:
//   i_clk48     48MHz system clock
//   i_rst48_n   asynchronous active-low reset
//   i_pulse     48kHz tick, one clock wide; the only cycle where state moves
//   i_sample    signed input sample
//   i_gate      note on/off, sampled only on pulse cycles
//   i_attack    level increment per tick in ATTACK (0 = instant)
//   i_decay     level decrement per tick in DECAY (0 = instant)
//   i_sustain   sustain level
//   i_release   level decrement per tick in RELEASE (0 = instant)
//   i_velocity  (ENV_VELOCITY_EN only) 8-bit note velocity, captured with the sample
//   o_sample    enveloped signed sample, holds between strobes
//   o_valid     one-cycle strobe when o_sample updates
//   o_state     0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//
// Optional feature macro: ENV_VELOCITY_EN adds i_velocity and one extra
// scaling stage (latency pulse -> o_valid becomes 3 cycles instead of 2).
module env_adsr #(
  parameter int SAMPLE_W = 16,
  parameter int LEVEL_W  = 16
) (
  input  logic                       i_clk48,
  input  logic                       i_rst48_n,
  input  logic                       i_pulse,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_gate,
  input  logic [LEVEL_W-1:0]         i_attack,
  input  logic [LEVEL_W-1:0]         i_decay,
  input  logic [LEVEL_W-1:0]         i_sustain,
  input  logic [LEVEL_W-1:0]         i_release,
`ifdef ENV_VELOCITY_EN
  input  logic [7:0]                 i_velocity,
`endif
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic                       o_valid,
  output logic [2:0]                 o_state
);

  localparam int PROD_W = SAMPLE_W + LEVEL_W + 1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Signed sample times unsigned level, floor-shifted back to sample width.
  // Since unity is all-ones the result magnitude never exceeds the input.
  function automatic logic signed [SAMPLE_W-1:0] scale_level(
    input logic signed [SAMPLE_W-1:0] s,
    input logic [LEVEL_W-1:0]         l
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    logic signed [PROD_W-1:0] p;
    a = PROD_W'(s);
    b = $signed({{(SAMPLE_W + 1){1'b0}}, l});
    p = a * b;
    return SAMPLE_W'(p >>> LEVEL_W);
  endfunction

  state_t               state;
  state_t               state_nxt;
  state_t               eff_state;
  logic [LEVEL_W-1:0]   level;
  logic [LEVEL_W-1:0]   level_nxt;
  logic [LEVEL_W:0]     attack_sum;
  logic [LEVEL_W:0]     decay_floor;
  logic signed [SAMPLE_W-1:0] s_q;
  logic                 v1;

  // 17-bit so neither the attack overflow nor the decay threshold wraps.
  assign attack_sum  = {1'b0, level} + {1'b0, i_attack};
  assign decay_floor = {1'b0, i_decay} + {1'b0, i_sustain};
  assign o_state     = state;

  // Next state/level: the gate first picks the state, then that state's step
  // is applied within the same pulse.
  always_comb begin
    eff_state = state;
    state_nxt = state;
    level_nxt = level;

    case (state)
      ST_IDLE, ST_RELEASE: begin
        if (i_gate) eff_state = ST_ATTACK;
        else        eff_state = state;
      end
      ST_ATTACK, ST_DECAY, ST_SUSTAIN: begin
        if (!i_gate) eff_state = ST_RELEASE;
        else         eff_state = state;
      end
      default: eff_state = ST_IDLE;
    endcase

    case (eff_state)
      ST_ATTACK: begin
        // Retrigger continues from the current level rather than from zero.
        if ((attack_sum >= {1'b0, LEVEL_MAX}) || (i_attack == '0)) begin
          level_nxt = LEVEL_MAX;
          state_nxt = ST_DECAY;
        end else begin
          level_nxt = attack_sum[LEVEL_W-1:0];
          state_nxt = ST_ATTACK;
        end
      end
      ST_DECAY: begin
        if (({1'b0, level} <= decay_floor) || (i_decay == '0)) begin
          level_nxt = i_sustain;
          state_nxt = ST_SUSTAIN;
        end else begin
          level_nxt = level - i_decay;
          state_nxt = ST_DECAY;
        end
      end
      ST_SUSTAIN: begin
        // Reload every tick so live sustain changes are followed.
        level_nxt = i_sustain;
        state_nxt = ST_SUSTAIN;
      end
      ST_RELEASE: begin
        if ((level <= i_release) || (i_release == '0)) begin
          level_nxt = '0;
          state_nxt = ST_IDLE;
        end else begin
          level_nxt = level - i_release;
          state_nxt = ST_RELEASE;
        end
      end
      default: begin
        level_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Envelope state, level and sample capture advance only on pulse cycles.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      state <= ST_IDLE;
      level <= '0;
      s_q   <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= i_pulse;
      if (i_pulse) begin
        state <= state_nxt;
        level <= level_nxt;
        s_q   <= i_sample;
      end
    end
  end

`ifdef ENV_VELOCITY_EN
  localparam int VPROD_W = SAMPLE_W + 9;

  // Scale by an unsigned 8-bit velocity, floor-shifted by 8.
  function automatic logic signed [SAMPLE_W-1:0] scale_vel(
    input logic signed [SAMPLE_W-1:0] s,
    input logic [7:0]                 v
  );
    logic signed [VPROD_W-1:0] a;
    logic signed [VPROD_W-1:0] b;
    logic signed [VPROD_W-1:0] p;
    a = VPROD_W'(s);
    b = $signed({{(SAMPLE_W + 1){1'b0}}, v});
    p = a * b;
    return SAMPLE_W'(p >>> 4'd8);
  endfunction

  logic [7:0]                 vel_q;
  logic [7:0]                 vel_d;
  logic signed [SAMPLE_W-1:0] prod16;
  logic                       v2;

  // Two-stage scaling: level first, then velocity; velocity travels with its
  // product so back-to-back pulses do not mix notes.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      vel_q    <= 8'd0;
      vel_d    <= 8'd0;
      prod16   <= '0;
      v2       <= 1'b0;
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      if (i_pulse) vel_q <= i_velocity;
      v2      <= v1;
      o_valid <= v2;
      if (v1) begin
        prod16 <= scale_level(s_q, level);
        vel_d  <= vel_q;
      end
      if (v2) o_sample <= scale_vel(prod16, vel_d);
    end
  end
`else
  // Output stage: level is already the post-update value one cycle after the pulse.
  always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
    if (!i_rst48_n) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= v1;
      if (v1) o_sample <= scale_level(s_q, level);
    end
  end
`endif

endmodule
